// File: rtl/alu_seq_pkg.sv
// Shared definitions for the slice-serial ALU sequencer: op encodings,
// sequencer states, slice width and the per-op slice control mapping.
package alu_seq_pkg;

   localparam int SLICE_W = 3;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_SUB    = 2'b01;
   localparam logic [1:0] OP_XOR    = 2'b10;
   localparam logic [1:0] OP_PASS_B = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // nx: carry chain enable, ns: sum path select (else pass b), n: output enable
   typedef struct packed {
      logic nx;
      logic ns;
      logic n;
   } slice_ctrl_t;

   function automatic slice_ctrl_t ctrl_for_op(input logic [1:0] op);
      slice_ctrl_t c;
      c.nx = 1'b1;
      c.ns = 1'b1;
      c.n  = 1'b1;
      case (op)
         OP_XOR: begin
            c.nx = 1'b0;
         end
         OP_PASS_B: begin
            c.nx = 1'b0;
            c.ns = 1'b0;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic is_arith(input logic [1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu3.sv
// 3-bit carry-lookahead ALU slice.
// nx gates the whole carry chain (0 gives a carry-free XOR), ns selects the
// sum (1) or the b operand (0), n=0 forces the result to zero.
// c[0]/c[1] are the carries into bits 1 and 2; c_out is the carry out of bit 2.
module alu3 (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       nx,
   input  logic       c_in,
   input  logic       ns,
   input  logic       n,
   output logic [2:0] q,
   output logic [1:0] c,
   output logic       c_out
);

   logic [2:0] g;
   logic [2:0] p;
   logic       c0;
   logic       c1;
   logic       c2;
   logic [2:0] s;

   // Generate/propagate terms and flattened lookahead carries
   always_comb begin
      g     = nx ? (a & b) : 3'b000;
      p     = a ^ b;
      c0    = nx & c_in;
      c1    = g[0] | (p[0] & c0);
      c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c_out = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      s     = p ^ {c2, c1, c0};
      c     = {c2, c1};
      q     = n ? (ns ? s : b) : 3'b000;
   end

endmodule

// File: rtl/alu_seq.sv
// Slice-serial ALU sequencer: drives one alu3 slice per cycle, LSB first,
// latching the inter-slice carry and assembling result and flags.
// Optional feature macro: ALU_SEQ_OVERFLOW_EN (registered signed overflow on flag_v).
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [1:0]                  op,
   input  logic [SLICE_W*SLICES-1:0]   a,
   input  logic [SLICE_W*SLICES-1:0]   b,
   output logic                        ready,
   output logic                        done,
   output logic [SLICE_W*SLICES-1:0]   q,
   output logic                        flag_c,
   output logic                        flag_z,
   output logic                        flag_v
);

   localparam int W  = SLICE_W * SLICES;
   localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] LAST_K = CW'(SLICES - 1);

   state_e          state;
   state_e          state_nxt;
   logic [CW-1:0]   k;
   logic            fin;
   logic [1:0]      op_r;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            cin_r;
   logic [W-1:0]    acc;
   logic [W-1:0]    acc_nxt;

   logic [2:0]      slice_a;
   logic [2:0]      slice_b;
   logic [2:0]      slice_q;
   logic [1:0]      slice_c;
   logic            slice_cout;
   slice_ctrl_t     ctrl;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; RUN spends one extra cycle (fin=1)
   // publishing the assembled word so no slice path reaches the ports
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (fin) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slice operand selection and result word merge for the current k
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      acc_nxt = acc;
      ctrl    = ctrl_for_op(op_r);
      for (int unsigned i = 0; i < SLICES; i++) begin
         if (k == CW'(i)) begin
            slice_a = a_r[i*SLICE_W +: SLICE_W];
            slice_b = b_r[i*SLICE_W +: SLICE_W];
            acc_nxt[i*SLICE_W +: SLICE_W] = slice_q;
         end
      end
      if (op_r == OP_SUB) begin
         slice_b = ~slice_b;
      end
   end

   alu3 u_alu3 (
      .a     (slice_a),
      .b     (slice_b),
      .nx    (ctrl.nx),
      .c_in  (cin_r),
      .ns    (ctrl.ns),
      .n     (ctrl.n),
      .q     (slice_q),
      .c     (slice_c),
      .c_out (slice_cout)
   );

   // Operand capture, slice stepping and result/flag publication
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k      <= '0;
         fin    <= 1'b0;
         op_r   <= OP_ADD;
         a_r    <= '0;
         b_r    <= '0;
         cin_r  <= 1'b0;
         acc    <= '0;
         q      <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= op;
                  a_r   <= a;
                  b_r   <= b;
                  k     <= '0;
                  fin   <= 1'b0;
                  cin_r <= (op == OP_SUB);
               end
            end
            RUN: begin
               if (!fin) begin
                  acc   <= acc_nxt;
                  cin_r <= slice_cout;
                  if (k == LAST_K) begin
                     fin <= 1'b1;
                  end else begin
                     k <= k + 1'b1;
                  end
               end else begin
                  q      <= acc;
                  flag_c <= is_arith(op_r) & cin_r;
                  flag_z <= (acc == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_OVERFLOW_EN
   logic v_r;

   // Overflow = carry into MSB xor carry out of MSB, taken on the last slice
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_r    <= 1'b0;
         flag_v <= 1'b0;
      end else if (state == RUN) begin
         if (!fin && (k == LAST_K)) begin
            v_r <= slice_cout ^ slice_c[1];
         end else if (fin) begin
            flag_v <= is_arith(op_r) & v_r;
         end
      end
   end
`else
   logic unused_slice_c;
   assign unused_slice_c = ^slice_c;
   assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and random operations against a
// plain-arithmetic reference, with timing, ignored-start and reset checks.
module tb_alu_seq;

   localparam int SLICES = 4;
   localparam int W = 3 * SLICES;

   logic         clk;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done;
   logic [W-1:0] q;
   logic         flag_c;
   logic         flag_z;
   logic         flag_v;

   int checks;
   int errors;

   alu_seq #(.SLICES(SLICES)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .q      (q),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .flag_v (flag_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain modular arithmetic on the whole word
   task automatic model(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output logic [W-1:0] eq, output logic ec, output logic ez, output logic ev);
      logic [W:0] full;
      full = '0;
      ec = 1'b0;
      ev = 1'b0;
      case (o)
         2'b00: begin
            full = {1'b0, xa} + {1'b0, xb};
            eq = full[W-1:0];
            ec = full[W];
            ev = (xa[W-1] == xb[W-1]) && (eq[W-1] != xa[W-1]);
         end
         2'b01: begin
            full = {1'b0, xa} + {1'b0, ~xb} + 1;
            eq = full[W-1:0];
            ec = full[W];
            ev = (xa[W-1] != xb[W-1]) && (eq[W-1] != xa[W-1]);
         end
         2'b10: eq = xa ^ xb;
         default: eq = xb;
      endcase
      ez = (eq == '0);
`ifndef ALU_SEQ_OVERFLOW_EN
      ev = 1'b0;
`endif
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input bit noise);
      logic [W-1:0] eq;
      logic ec, ez, ev;
      int done_edge;
      int pulses;
      int waited;
      model(o, xa, xb, eq, ec, ez, ev);
      waited = 0;
      while (!ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check({tag, "_ready_wait"}, 32'(ready), 32'd1);
      @(negedge clk);
      start = 1'b1; op = o; a = xa; b = xb;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      check({tag, "_busy"}, 32'(ready), 32'd0);
      done_edge = -1;
      pulses = 0;
      for (int e = 1; e <= SLICES + 3; e++) begin
         if (noise && (e == 3 || e == SLICES + 2)) begin
            start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            pulses++;
            if (done_edge < 0) done_edge = e;
         end
         if (e == SLICES + 1) check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
         if (e == SLICES + 2) check({tag, "_ready_after"}, 32'(ready), 32'd1);
      end
      check({tag, "_done_edge"}, 32'(done_edge), 32'(SLICES + 1));
      check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_q"}, 32'(q), 32'(eq));
      check({tag, "_c"}, 32'(flag_c), 32'(ec));
      check({tag, "_z"}, 32'(flag_z), 32'(ez));
      check({tag, "_v"}, 32'(flag_v), 32'(ev));
   endtask

   initial begin
      int seen_done;
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add_ovf",  2'b00, 12'h7FF, 12'h001, 1'b0);
      run_op("add_wrap", 2'b00, 12'hFFF, 12'h001, 1'b0);
      run_op("sub_eq",   2'b01, 12'h005, 12'h005, 1'b0);
      run_op("sub_neg",  2'b01, 12'h000, 12'h001, 1'b0);
      run_op("xor",      2'b10, 12'hA5A, 12'h0FF, 1'b0);
      run_op("pass_b",   2'b11, 12'h123, 12'h456, 1'b0);
      run_op("noise",    2'b00, 12'h234, 12'h111, 1'b1);
      run_op("pre_rst",  2'b00, 12'hFFF, 12'h002, 1'b0);

      // Reset during the second RUN cycle
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 12'h0F0; b = 12'h00F;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_q", 32'(q), 32'd0);
      check("midrst_flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < SLICES + 4; i++) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
      run_op("post_rst", 2'b00, 12'h001, 12'h002, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", 2'($urandom), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
